// File: rtl/ad_burst_packer_pkg.sv
// ad_burst_packer_pkg: shared defaults, width helpers and mode encoding for the AD burst packer
package ad_burst_packer_pkg;
  localparam int DATA_W_D    = 16;
  localparam int CH_NUM_D    = 2;
  localparam int BURST_LEN_D = 8;
  localparam int OVF_W_D     = 8;

  typedef enum logic {MODE_ALL = 1'b0, MODE_SINGLE = 1'b1} mode_e;

  function automatic int words_w(input int burst_len, input int ch_num);
    return $clog2(burst_len * ch_num + 1);
  endfunction

  function automatic int sel_w(input int ch_num);
    return ch_num > 1 ? $clog2(ch_num) : 1;
  endfunction
endpackage

// File: rtl/ad_burst_packer_if.sv
// ad_burst_packer_if: capture-side sample bus and drain-side burst bus of the packer
interface ad_burst_packer_if
  import ad_burst_packer_pkg::*;
#(
  parameter int DATA_W    = DATA_W_D,
  parameter int CH_NUM    = CH_NUM_D,
  parameter int BURST_LEN = BURST_LEN_D,
  parameter int OVF_W     = OVF_W_D
);
  localparam int LW = sel_w(CH_NUM);
  localparam int WW = words_w(BURST_LEN, CH_NUM);
  logic [CH_NUM*DATA_W-1:0] ad_data;
  logic                     ad_valid;
  logic                     mode_single;
  logic [LW-1:0]            ch_sel;
  logic                     flush;
  logic                     burst_avail;
  logic                     burst_tog;
  logic [WW-1:0]            burst_words;
  logic                     rd_en;
  logic [DATA_W-1:0]        rd_data;
  logic                     rd_valid;
  logic                     rd_last;
  logic                     ovf;
  logic [OVF_W-1:0]         ovf_cnt;
  modport master (
    output ad_data, ad_valid, mode_single, ch_sel, flush, rd_en,
    input  burst_avail, burst_tog, burst_words, rd_data, rd_valid, rd_last, ovf, ovf_cnt
  );
  modport slave (
    input  ad_data, ad_valid, mode_single, ch_sel, flush, rd_en,
    output burst_avail, burst_tog, burst_words, rd_data, rd_valid, rd_last, ovf, ovf_cnt
  );
endinterface

// File: rtl/ad_burst_packer_bank.sv
// ad_burst_bank: one ping-pong bank holding sample rows, fill count, full flag and the
// mode/channel latched on its first sample; presents the word at (sample, channel).
module ad_burst_bank
  import ad_burst_packer_pkg::*;
#(
  parameter int DATA_W    = DATA_W_D,
  parameter int CH_NUM    = CH_NUM_D,
  parameter int BURST_LEN = BURST_LEN_D,
  localparam int CW = $clog2(BURST_LEN + 1),
  localparam int SW = $clog2(BURST_LEN),
  localparam int LW = sel_w(CH_NUM),
  localparam int WW = words_w(BURST_LEN, CH_NUM)
)(
  input  logic                     clk_50_90,
  input  logic                     reset_syn,
  input  logic                     i_wr,
  input  logic                     i_close,
  input  logic                     i_clr,
  input  logic [CH_NUM*DATA_W-1:0] i_data,
  input  logic                     i_mode_single,
  input  logic [LW-1:0]            i_ch_sel,
  input  logic [SW-1:0]            i_rd_s,
  input  logic [LW-1:0]            i_rd_c,
  output logic                     o_full,
  output logic [CW-1:0]            o_count,
  output logic [WW-1:0]            o_words,
  output logic                     o_single,
  output logic [DATA_W-1:0]        o_word
);
  mode_e                    r_mode;
  logic                     r_full;
  logic [CW-1:0]            r_count;
  logic [LW-1:0]            r_sel;
  logic [CH_NUM*DATA_W-1:0] r_mem [BURST_LEN];
  logic [CW-1:0]            w_base;
  logic [CH_NUM*DATA_W-1:0] w_row;
  logic [DATA_W-1:0]        w_ch [CH_NUM];

  // a clear in the same cycle as a write restarts the bank at entry 0
  assign w_base = i_clr ? '0 : r_count;

  always_ff @(posedge clk_50_90 or posedge reset_syn) begin
    if (reset_syn) begin
      r_mode  <= MODE_ALL;
      r_sel   <= '0;
      r_full  <= 1'b0;
      r_count <= '0;
    end else begin
      r_count <= w_base + CW'(i_wr);
      r_full  <= (r_full & ~i_clr) | i_close;
      if (i_wr && w_base == '0) begin
        r_mode <= i_mode_single ? MODE_SINGLE : MODE_ALL;
        r_sel  <= i_ch_sel;
      end
    end
  end

  always_ff @(posedge clk_50_90)
    if (i_wr) r_mem[w_base[SW-1:0]] <= i_data;

  assign w_row = r_mem[i_rd_s];
  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    assign w_ch[c] = w_row[c*DATA_W +: DATA_W];
  end

  assign o_full   = r_full;
  assign o_count  = r_count;
  assign o_single = r_mode == MODE_SINGLE;
  assign o_words  = o_single ? WW'(r_count) : WW'(r_count * CH_NUM);
  assign o_word   = w_ch[o_single ? r_sel : i_rd_c];
endmodule

// File: rtl/ad_burst_packer.sv
// ad_burst_packer: packs multi-channel AD samples into two ping-pong banks, announces full
// bursts with a level and a CDC-safe toggle, and drains them one word per cycle.
module ad_burst_packer
  import ad_burst_packer_pkg::*;
#(
  parameter int DATA_W    = DATA_W_D,
  parameter int CH_NUM    = CH_NUM_D,
  parameter int BURST_LEN = BURST_LEN_D,
  parameter int OVF_W     = OVF_W_D
)(
  input logic               clk_50_90,
  input logic               reset_syn,
  ad_burst_packer_if.slave  bus
);
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int SW = $clog2(BURST_LEN);
  localparam int LW = sel_w(CH_NUM);
  localparam int WW = words_w(BURST_LEN, CH_NUM);

  logic              r_wr_bank, r_rd_bank, r_tog, r_ovf, r_rd_valid, r_rd_last;
  logic [SW-1:0]     r_rd_s;
  logic [LW-1:0]     r_rd_c;
  logic [OVF_W-1:0]  r_ovf_cnt;
  logic [DATA_W-1:0] r_rd_data;
  logic [1:0]        w_full, w_single, w_wr, w_close, w_clr;
  logic [CW-1:0]     w_count [2];
  logic [WW-1:0]     w_words [2];
  logic [DATA_W-1:0] w_word [2];
  logic              w_rd_go, w_c_last, w_last, w_open, w_acc, w_done, w_drop;
  logic [CW-1:0]     w_next;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ad_burst_bank #(.DATA_W(DATA_W), .CH_NUM(CH_NUM), .BURST_LEN(BURST_LEN)) u_bank (
      .clk_50_90     (clk_50_90),
      .reset_syn     (reset_syn),
      .i_wr          (w_wr[b]),
      .i_close       (w_close[b]),
      .i_clr         (w_clr[b]),
      .i_data        (bus.ad_data),
      .i_mode_single (bus.mode_single),
      .i_ch_sel      (bus.ch_sel),
      .i_rd_s        (r_rd_s),
      .i_rd_c        (r_rd_c),
      .o_full        (w_full[b]),
      .o_count       (w_count[b]),
      .o_words       (w_words[b]),
      .o_single      (w_single[b]),
      .o_word        (w_word[b])
    );
  end

  // the bank freed by a final fetch is writable in that same cycle
  always_comb begin
    w_rd_go  = bus.rd_en & w_full[r_rd_bank];
    w_c_last = w_single[r_rd_bank] | (r_rd_c == LW'(CH_NUM - 1));
    w_last   = w_rd_go & w_c_last & ((CW'(r_rd_s) + CW'(1)) == w_count[r_rd_bank]);
    w_clr    = {w_last & r_rd_bank, w_last & ~r_rd_bank};
    w_open   = ~w_full[r_wr_bank] | w_clr[r_wr_bank];
    w_acc    = bus.ad_valid & w_open;
    w_drop   = bus.ad_valid & ~w_open;
    w_next   = (w_clr[r_wr_bank] ? '0 : w_count[r_wr_bank]) + CW'(w_acc);
    w_done   = w_open & ((w_next == CW'(BURST_LEN)) | (bus.flush & (w_next != '0)));
    w_wr     = {w_acc & r_wr_bank, w_acc & ~r_wr_bank};
    w_close  = {w_done & r_wr_bank, w_done & ~r_wr_bank};
  end

  always_ff @(posedge clk_50_90 or posedge reset_syn) begin
    if (reset_syn) begin
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_tog      <= 1'b0;
      r_ovf      <= 1'b0;
      r_ovf_cnt  <= '0;
      r_rd_s     <= '0;
      r_rd_c     <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      if (w_done) begin
        r_tog     <= ~r_tog;
        r_wr_bank <= ~r_wr_bank;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_ovf_cnt != '1) r_ovf_cnt <= r_ovf_cnt + OVF_W'(1);
      end
      r_rd_valid <= w_rd_go;
      r_rd_last  <= w_last;
      if (w_rd_go) begin
        r_rd_data <= w_word[r_rd_bank];
        if (w_last) begin
          r_rd_s    <= '0;
          r_rd_c    <= '0;
          r_rd_bank <= ~r_rd_bank;
        end else if (w_c_last) begin
          r_rd_c <= '0;
          r_rd_s <= r_rd_s + SW'(1);
        end else begin
          r_rd_c <= r_rd_c + LW'(1);
        end
      end
    end
  end

  assign bus.burst_avail = |w_full;
  assign bus.burst_tog   = r_tog;
  assign bus.burst_words = w_words[r_rd_bank];
  assign bus.rd_data     = r_rd_data;
  assign bus.rd_valid    = r_rd_valid;
  assign bus.rd_last     = r_rd_last;
  assign bus.ovf         = r_ovf;
  assign bus.ovf_cnt     = r_ovf_cnt;
endmodule

// File: tb/tb_ad_burst_packer.sv
// tb_ad_burst_packer: directed and random stimulus against a queue-based burst model;
// a second instance with a 2-bit overflow counter shares the stimulus.
module tb_ad_burst_packer;
  import ad_burst_packer_pkg::*;
  localparam int DW = 16, CH = 2, BL = 8;

  logic clk_50_90 = 1'b0;
  logic reset_syn = 1'b0;
  always #10 clk_50_90 = ~clk_50_90;

  ad_burst_packer_if #(.DATA_W(DW), .CH_NUM(CH), .BURST_LEN(BL), .OVF_W(8)) bif ();
  ad_burst_packer_if #(.DATA_W(DW), .CH_NUM(CH), .BURST_LEN(BL), .OVF_W(2)) bif2 ();

  ad_burst_packer #(.DATA_W(DW), .CH_NUM(CH), .BURST_LEN(BL), .OVF_W(8)) dut (
    .clk_50_90 (clk_50_90), .reset_syn (reset_syn), .bus (bif.slave));
  ad_burst_packer #(.DATA_W(DW), .CH_NUM(CH), .BURST_LEN(BL), .OVF_W(2)) dut2 (
    .clk_50_90 (clk_50_90), .reset_syn (reset_syn), .bus (bif2.slave));

  assign bif2.ad_data     = bif.ad_data;
  assign bif2.ad_valid    = bif.ad_valid;
  assign bif2.mode_single = bif.mode_single;
  assign bif2.ch_sel      = bif.ch_sel;
  assign bif2.flush       = bif.flush;
  assign bif2.rd_en       = bif.rd_en;

  int checks = 0, errors = 0;
  bit [15:0]   pendw[$];
  int          plen[$];
  logic [31:0] curq[$];
  bit          cur_single, cur_sel, tog, ev, el;
  bit [15:0]   ed;
  int          ridx, ovfc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic void mreset();
    pendw.delete(); plen.delete(); curq.delete();
    cur_single = 0; cur_sel = 0; tog = 0; ev = 0; el = 0; ed = 0; ridx = 0; ovfc = 0;
  endfunction

  // freeing by the final fetch happens before the sample of the same edge is judged
  task automatic model_edge();
    ev = 0; el = 0;
    if (bif.rd_en && plen.size() > 0) begin
      ev = 1;
      ed = pendw.pop_front();
      el = (ridx == plen[0] - 1);
      if (el) begin void'(plen.pop_front()); ridx = 0; end
      else ridx++;
    end
    if (bif.ad_valid) begin
      if (plen.size() == 2) ovfc++;
      else begin
        if (curq.size() == 0) begin cur_single = bif.mode_single; cur_sel = bif.ch_sel; end
        curq.push_back(bif.ad_data);
      end
    end
    if (curq.size() == BL || (bif.flush && curq.size() > 0)) begin
      foreach (curq[k]) begin
        if (cur_single) pendw.push_back(cur_sel ? curq[k][31:16] : curq[k][15:0]);
        else begin pendw.push_back(curq[k][15:0]); pendw.push_back(curq[k][31:16]); end
      end
      plen.push_back(cur_single ? curq.size() : 2 * curq.size());
      curq.delete();
      tog = ~tog;
    end
  endtask

  function automatic int exp_words();
    return plen.size() > 0 ? plen[0] : (cur_single ? curq.size() : 2 * curq.size());
  endfunction

  task automatic check_all();
    chk("rd_valid", bif.rd_valid, ev);
    chk("rd_last", bif.rd_last, el);
    chk("rd_data", bif.rd_data, ed);
    chk("burst_tog", bif.burst_tog, tog);
    chk("burst_avail", bif.burst_avail, plen.size() > 0);
    chk("burst_words", bif.burst_words, exp_words());
    chk("ovf", bif.ovf, ovfc > 0);
    chk("ovf_cnt", bif.ovf_cnt, ovfc > 255 ? 255 : ovfc);
    chk("ovf_cnt_w2", bif2.ovf_cnt, ovfc > 3 ? 3 : ovfc);
    chk("rd_data_w2", bif2.rd_data, ed);
  endtask

  task automatic cyc(input bit v, input bit fl, input bit re, input logic [31:0] d);
    bif.ad_valid = v; bif.flush = fl; bif.rd_en = re; bif.ad_data = d;
    @(posedge clk_50_90);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    bif.ad_valid = 0; bif.flush = 0; bif.rd_en = 0;
    reset_syn = 1;
    #2;
    mreset();
    chk("rst_rd_valid", bif.rd_valid, 0);
    chk("rst_rd_last", bif.rd_last, 0);
    chk("rst_rd_data", bif.rd_data, 0);
    chk("rst_tog", bif.burst_tog, 0);
    chk("rst_avail", bif.burst_avail, 0);
    chk("rst_words", bif.burst_words, 0);
    chk("rst_ovf", bif.ovf, 0);
    chk("rst_ovf_cnt", bif.ovf_cnt, 0);
    @(posedge clk_50_90);
    #9 reset_syn = 0;
    @(posedge clk_50_90);
    #1 check_all();
  endtask

  initial begin
    bif.ad_data = '0; bif.ad_valid = 0; bif.mode_single = 0; bif.ch_sel = 0;
    bif.flush = 0; bif.rd_en = 0;
    #1 do_reset();
    // two-channel burst with counting data
    for (int i = 0; i < BL; i++) cyc(1, 0, 0, {16'h100 + 16'(i), 16'(i)});
    chk("t1_words", bif.burst_words, 16);
    chk("t1_tog", bif.burst_tog, 1);
    for (int i = 0; i < 2 * BL; i++) begin
      cyc(0, 0, 1, 0);
      chk("t1_data", bif.rd_data, i[0] ? 16'h100 + 16'(i / 2) : 16'(i / 2));
    end
    chk("t1_last", bif.rd_last, 1);
    cyc(0, 0, 0, 0);
    // single mode on channel 1, mode dropped mid-burst
    bif.mode_single = 1; bif.ch_sel = 1;
    for (int i = 0; i < BL; i++) begin
      if (i == 3) begin bif.mode_single = 0; bif.ch_sel = 0; end
      cyc(1, 0, 0, {16'h100 + 16'(i), 16'($urandom)});
    end
    chk("t2_words", bif.burst_words, 8);
    for (int i = 0; i < BL; i++) begin
      cyc(0, 0, 1, 0);
      chk("t2_data", bif.rd_data, 16'h100 + 16'(i));
    end
    cyc(0, 1, 0, 0);
    // partial burst closed by flush
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, $urandom);
    cyc(0, 1, 0, 0);
    chk("t3_words", bif.burst_words, 6);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0);
    chk("t3_last", bif.rd_last, 1);
    for (int i = 0; i < BL; i++) cyc(1, 0, 0, $urandom);
    for (int i = 0; i < 2 * BL + 1; i++) cyc(0, 0, 1, 0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) begin
        bif.mode_single = 1'($urandom); bif.ch_sel = 1'($urandom);
      end
      cyc(1'($urandom), $urandom_range(15) == 0, $urandom_range(3) != 0, $urandom);
    end
    // overflow and saturation
    do_reset();
    bif.mode_single = 0;
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, $urandom);
    chk("ovf_set", bif.ovf, 1);
    chk("ovf_cnt4", bif.ovf_cnt, 4);
    chk("ovf_sat", bif2.ovf_cnt, 3);
    for (int i = 0; i < 2; i++) cyc(1, 0, 0, $urandom);
    chk("ovf_cnt6", bif.ovf_cnt, 6);
    chk("ovf_sat2", bif2.ovf_cnt, 3);
    // sample arriving with the final fetch of the bank it targets
    for (int i = 0; i < 2 * BL - 1; i++) cyc(0, 0, 1, 0);
    cyc(1, 0, 1, 32'hBEEF_0A5A);
    chk("free_ovf", bif.ovf_cnt, 6);
    for (int i = 0; i < 2 * BL; i++) cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    chk("free_words", bif.burst_words, 2);
    cyc(0, 0, 1, 0);
    chk("free_e0c0", bif.rd_data, 16'h0A5A);
    cyc(0, 0, 1, 0);
    chk("free_e0c1", bif.rd_data, 16'hBEEF);
    // reset mid-fill and mid-drain
    for (int i = 0; i < BL; i++) cyc(1, 0, 0, $urandom);
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, $urandom);
    do_reset();
    for (int i = 0; i < BL; i++) cyc(1, 0, 0, $urandom);
    chk("post_rst_tog", bif.burst_tog, 1);
    chk("post_rst_words", bif.burst_words, 16);
    for (int i = 0; i < 2 * BL + 1; i++) cyc(0, 0, 1, 0);
    chk("post_rst_avail", bif.burst_avail, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
